ram_test: RTL and testbench
===========================

Name: ram_test

Overview:
- Single-port synchronous 32K x 16 block RAM backing the HuC6270 VDC VRAM, used when the VRAM wrapper is not in simulation mode.
- One address bus serves both reads and writes, with a registered read port.
- A reset-triggered clear engine zeroes every word, because games expect VRAM to be zero at start-up.
- A `ready` flag reports when the clear has finished.

Parameters:
- ADDR_W, 15, address width; depth = 2**ADDR_W words.
- DATA_W, 16, word width.
- CLEAR_ON_RESET, 1, when 1 reset starts a zero-fill of all words; when 0 reset only clears `q` and `ready` rises on the next cycle.

Ports:
- clock  input  1  single clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- address  input  ADDR_W  word address for the read or write.
- data  input  DATA_W  write data.
- wren  input  1  write enable; when high, writes `data` to `address` on the clock edge.
- q  output  DATA_W  registered read data.
- ready  output  1  high when the clear engine is idle and the user port is live.

Behaviour:
- Reset (sampled at a rising edge with reset=1):
  - `q` <= 0 and `ready` <= 0.
  - The clear pointer is set to 0.
  - Reset has priority over every other input, including `wren`.
- Clear engine (CLEAR_ON_RESET=1), states CLEAR and IDLE:
  - Reset forces the CLEAR state.
  - In CLEAR, each edge writes 0 to mem[ptr] and increments ptr.
  - The edge that writes word 2**ADDR_W-1 moves the engine to IDLE and sets `ready` to 1.
  - A full clear therefore takes exactly 2**ADDR_W cycles after reset deasserts (32768 at default), and `ready` is high in the following cycle.
  - The clear pointer wraps cleanly from 2**ADDR_W-1; it never indexes beyond the depth.
- During CLEAR:
  - `wren`, `address` and `data` are ignored; no user write reaches the array.
  - `q` is held at 0.
- Reset asserted mid-clear restarts the clear from address 0.
- Reset asserted while IDLE re-clears the whole array; memory contents are not preserved across reset.
- Read path (IDLE):
  - Every edge registers q <= mem[address], regardless of `wren`.
  - Latency is 1 cycle: `address` presented before edge N gives valid `q` after edge N.
  - `q` holds its value only as long as `address` and the contents are unchanged; there is no separate read enable.
- Write path (IDLE):
  - wren=1 at an edge gives mem[address] <= data.
  - Writes are full-width; there are no byte enables.
- Read-during-write to the same address is read-first: `q` returns the old contents, and the new data is visible from the next read edge onward.
- Address range: all 2**ADDR_W addresses are valid; the input width is exactly ADDR_W, so no out-of-range access exists.
- Implementation must infer a single block RAM with a registered output.
- Simulation-only print statements are permitted but not required.

Test Plan:
- Assert reset for 2 cycles, release, count cycles until `ready`=1: exactly 32768 cycles. Then reading addresses 0x0000, 0x1234 and 0x7FFF returns 0x0000 each, one cycle after the address is presented.
- After `ready`, write 0xBEEF to 0x0010 and 0x1234 to 0x7FFF, then read both back: `q` = 0xBEEF and 0x1234 with 1-cycle latency. Neighbouring words 0x000F and 0x0011 still read 0.
- Write 0xAAAA to 0x0020, then on the next cycle write 0x5555 to 0x0020 with the same address: that cycle's `q` = 0xAAAA, and the following read gives 0x5555.
- With `wren`=1, address 0x0005 and data 0xFFFF held throughout the clear: after `ready`, address 0x0005 reads 0x0000 and `q` was 0 for the whole clear.
- Fill several words, then pulse reset midway through a second clear (about 1000 cycles in): `ready` stays low, and the total from the last reset release to `ready` is 32768 cycles. All previously written words read 0.
- Back-to-back writes to 0x7FFE, 0x7FFF and 0x0000 followed by back-to-back reads: each word returns its own value, with no aliasing across the top-of-range wrap.

Source files
------------

// File: rtl/ram_test.sv
// ram_test - single-port synchronous block RAM with a reset-triggered clear.
//
// Backs the VDC VRAM. One address bus serves both reads and writes. The read
// port is registered and read-first. Reset starts a zero-fill of every word.
// While the fill runs, the user port is ignored and q is held at zero.
//
// Ports
//   clock    in   rising-edge clock for all state
//   reset    in   synchronous, active-high; restarts the clear engine
//   address  in   [ADDR_W-1:0] word address for the read or write
//   data     in   [DATA_W-1:0] write data
//   wren     in   write enable (ignored while clearing)
//   q        out  [DATA_W-1:0] registered read data, 1-cycle latency
//   ready    out  high once the clear engine is idle and the user port is live
//
// CLEAR_ON_RESET=0 skips the fill: reset only clears q, and ready rises on
// the following cycle.
module ram_test #(
  parameter int unsigned ADDR_W         = 15,
  parameter int unsigned DATA_W         = 16,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data,
  input  logic              wren,
  output logic [DATA_W-1:0] q,
  output logic              ready
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic {
    CLEAR,
    IDLE
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [ADDR_W-1:0]   ptr;
  logic                clearing;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;

  logic [DATA_W-1:0]   mem [0:DEPTH-1];

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= CLEAR_ON_RESET ? CLEAR : IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: the edge that writes the top word ends the clear
  always_comb begin
    state_next = state;
    if (state == CLEAR && ptr == '1) begin
      state_next = IDLE;
    end
  end

  // Output logic: the clear engine borrows the single write port
  always_comb begin
    clearing  = (state == CLEAR);
    mem_we    = clearing | wren;
    mem_waddr = clearing ? ptr : address;
    mem_wdata = clearing ? '0 : data;
  end

  // Clear pointer; ADDR_W bits wide, so it wraps without leaving the array
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr <= '0;
    end else if (clearing) begin
      ptr <= ptr + 1'b1;
    end
  end

  // Array write port; reset blocks every write, including user writes
  always_ff @(posedge clock) begin
    if (mem_we && !reset) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Registered read, read-first against a same-edge write
  always_ff @(posedge clock) begin
    if (reset || clearing) begin
      q <= '0;
    end else begin
      q <= mem[address];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ready <= 1'b0;
    end else begin
      ready <= (state_next == IDLE);
    end
  end

endmodule

// File: tb/tb_ram_test.sv
// tb_ram_test - randomized scoreboard bench for ram_test.
// Every user-port cycle pushes the expected q (old contents, read-first) onto
// a queue; a monitor pops and compares at the falling edge after the read.
module tb_ram_test;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [14:0] address = '0;
  logic [15:0] data = '0;
  logic        wren = 1'b0;
  logic [15:0] q;
  logic        ready;

  // Small instance without the clear engine
  logic        nc_reset = 1'b1;
  logic [3:0]  nc_address = '0;
  logic [7:0]  nc_data = '0;
  logic        nc_wren = 1'b0;
  logic [7:0]  nc_q;
  logic        nc_ready;

  int          checks = 0;
  int          failures = 0;

  logic [15:0] model [0:32767];
  logic [15:0] exp_q [$];
  logic [15:0] sb_exp;
  bit          issue = 1'b0;
  bit          pend = 1'b0;

  always #5 clock = ~clock;

  ram_test #(.ADDR_W(15), .DATA_W(16), .CLEAR_ON_RESET(1'b1)) dut (
    .clock   (clock),
    .reset   (reset),
    .address (address),
    .data    (data),
    .wren    (wren),
    .q       (q),
    .ready   (ready)
  );

  ram_test #(.ADDR_W(4), .DATA_W(8), .CLEAR_ON_RESET(1'b0)) dut_nc (
    .clock   (clock),
    .reset   (nc_reset),
    .address (nc_address),
    .data    (nc_data),
    .wren    (nc_wren),
    .q       (nc_q),
    .ready   (nc_ready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a read issued before edge N is valid after edge N
  always @(posedge clock) pend <= issue;

  always @(negedge clock) begin
    if (pend) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_underflow: got q=%0h expected no output", q);
      end else begin
        sb_exp = exp_q.pop_front();
        checks++;
        if (q !== sb_exp) begin
          failures++;
          $display("FAIL sb_read: got q=%0h expected %0h", q, sb_exp);
        end
      end
    end
  end

  function automatic void model_clear();
    foreach (model[i]) model[i] = '0;
  endfunction

  // One user-port cycle: every edge reads, optionally writes
  task automatic op(input logic [14:0] a, input logic w, input logic [15:0] d);
    address = a;
    wren    = w;
    data    = d;
    exp_q.push_back(model[a]);
    issue   = 1'b1;
    @(posedge clock);
    #1;
    if (w) model[a] = d;
  endtask

  task automatic idle_port();
    issue = 1'b0;
    wren  = 1'b0;
    repeat (2) @(posedge clock);
    #1;
  endtask

  // Count edges after reset release until ready is seen, bounded
  task automatic wait_ready(output int n, output bit q_nonzero);
    n = 0;
    q_nonzero = 1'b0;
    do begin
      @(posedge clock);
      #1;
      n++;
      if (q !== 16'h0000) q_nonzero = 1'b1;
    end while (ready !== 1'b1 && n < 40000);
  endtask

  int  n;
  bit  qnz;
  bit  early_ready;
  logic [14:0] ra;

  initial begin
    // Instance without clear: ready follows reset by one cycle
    @(posedge clock);
    #1;
    check("nc_reset_ready", {31'b0, nc_ready}, 32'd0);
    check("nc_reset_q", {24'b0, nc_q}, 32'd0);
    nc_reset = 1'b0;
    nc_wren = 1'b1; nc_address = 4'h3; nc_data = 8'hA5;
    @(posedge clock);
    #1;
    check("nc_ready_next", {31'b0, nc_ready}, 32'd1);
    nc_wren = 1'b0;
    @(posedge clock);
    #1;
    check("nc_readback", {24'b0, nc_q}, 32'h0000_00A5);

    // Main instance: 2-cycle reset with a write held on the port throughout
    wren = 1'b1; address = 15'h0005; data = 16'hFFFF;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("reset_q", {16'b0, q}, 32'd0);
    check("reset_ready", {31'b0, ready}, 32'd0);
    reset = 1'b0;
    model_clear();
    wait_ready(n, qnz);
    check("clear_cycles", n, 32'd32768);
    check("q_zero_during_clear", {31'b0, qnz}, 32'd0);
    wren = 1'b0;

    // Freshly cleared words, including the word hammered during the clear
    op(15'h0000, 1'b0, 16'h0);
    op(15'h1234, 1'b0, 16'h0);
    op(15'h7FFF, 1'b0, 16'h0);
    op(15'h0005, 1'b0, 16'h0);

    // Write and read back, neighbours untouched
    op(15'h0010, 1'b1, 16'hBEEF);
    op(15'h7FFF, 1'b1, 16'h1234);
    op(15'h0010, 1'b0, 16'h0);
    op(15'h7FFF, 1'b0, 16'h0);
    op(15'h000F, 1'b0, 16'h0);
    op(15'h0011, 1'b0, 16'h0);

    // Read-during-write is read-first
    op(15'h0020, 1'b1, 16'hAAAA);
    op(15'h0020, 1'b1, 16'h5555);
    op(15'h0020, 1'b0, 16'h0);

    // Top-of-range wrap, back to back
    op(15'h7FFE, 1'b1, 16'h1111);
    op(15'h7FFF, 1'b1, 16'h2222);
    op(15'h0000, 1'b1, 16'h3333);
    op(15'h7FFE, 1'b0, 16'h0);
    op(15'h7FFF, 1'b0, 16'h0);
    op(15'h0000, 1'b0, 16'h0);

    // Random traffic, biased to a small window for frequent address reuse
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 3))
        0:       ra = 15'($urandom);
        1:       ra = 15'h7FF8 + 15'($urandom_range(0, 15));
        default: ra = 15'($urandom_range(0, 31));
      endcase
      op(ra, 1'($urandom_range(0, 1)), 16'($urandom));
    end
    idle_port();

    // Second clear interrupted by reset about 1000 cycles in
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    early_ready = 1'b0;
    repeat (1000) begin
      @(posedge clock);
      #1;
      if (ready !== 1'b0) early_ready = 1'b1;
    end
    check("ready_low_mid_clear", {31'b0, early_ready}, 32'd0);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("midreset_ready", {31'b0, ready}, 32'd0);
    reset = 1'b0;
    model_clear();
    wait_ready(n, qnz);
    check("restart_clear_cycles", n, 32'd32768);
    check("q_zero_during_restart", {31'b0, qnz}, 32'd0);

    // Everything written before is gone
    op(15'h0010, 1'b0, 16'h0);
    op(15'h7FFF, 1'b0, 16'h0);
    op(15'h0020, 1'b0, 16'h0);
    op(15'h7FFE, 1'b0, 16'h0);
    op(15'h0000, 1'b0, 16'h0);
    for (int i = 0; i < 32; i++) begin
      op(15'($urandom_range(0, 31)), 1'b0, 16'h0);
    end
    idle_port();

    check("scoreboard_drain", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
